// File: rtl/seg7_scan_driver_pkg.sv
// rtl/seg7_scan_driver_pkg.sv - shared segment constants and scan-state encoding
package seg7_scan_driver_pkg;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    GUARD = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_scan_driver_hex_to_7seg.sv
// rtl/seg7_scan_driver_hex_to_7seg.sv - combinational hex nibble to active-low segment decode
module hex_to_7seg
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup; every nibble value maps to a glyph
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed common-anode seven-segment scan driver
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int GUARD_CYC  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [3:0]  anode_n,
  output logic [6:0]  cathode_n,
  output logic        dp_n
);

  localparam int DIV   = CLK_FREQ / REFRESH_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GRD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [GRD_W-1:0] GRD_LOAD  = GRD_W'(GUARD_CYC - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic [GRD_W-1:0] guard_cnt;
  scan_state_t      state;
  scan_state_t      state_next;
  logic             enter_guard;
  logic             enter_show;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic [3:0]       nibble;
  logic             dp_lat;
  logic             blank_lat;
  logic [6:0]       seg;

  assign tick = (div_cnt == CNT_LAST);

  hex_to_7seg u_dec (
    .nibble (nibble),
    .seg    (seg)
  );

  // Free-running refresh divider, one-cycle tick at terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Scan state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= OFF;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the digit advances only when leaving SHOW
  always_comb begin
    state_next  = state;
    enter_guard = 1'b0;
    enter_show  = 1'b0;
    idx_next    = (state == SHOW) ? idx + 2'd1 : idx;
    case (state)
      OFF: begin
        if (tick) begin
          state_next  = GUARD;
          enter_guard = 1'b1;
        end
      end
      GUARD: begin
        if (guard_cnt == '0) begin
          state_next = SHOW;
          enter_show = 1'b1;
        end
      end
      SHOW: begin
        if (tick) begin
          state_next  = GUARD;
          enter_guard = 1'b1;
        end
      end
      default: state_next = OFF;
    endcase
  end

  // Digit latch and guard countdown; inputs are captured only on guard entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= 2'd0;
      nibble    <= 4'h0;
      dp_lat    <= 1'b0;
      blank_lat <= 1'b0;
      guard_cnt <= '0;
    end else if (enter_guard) begin
      idx       <= idx_next;
      nibble    <= data_in[{idx_next, 2'b00} +: 4];
      dp_lat    <= dp_in[idx_next];
      blank_lat <= blank_in[idx_next];
      guard_cnt <= GRD_LOAD;
    end else if (state == GUARD && guard_cnt != '0) begin
      guard_cnt <= guard_cnt - 1'b1;
    end
  end

  // Registered drive: all-off through the guard, then the latched digit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode_n   <= ANODE_OFF;
      cathode_n <= SEG_OFF;
      dp_n      <= 1'b1;
    end else if (enter_guard) begin
      anode_n   <= ANODE_OFF;
      cathode_n <= SEG_OFF;
      dp_n      <= 1'b1;
    end else if (enter_show) begin
      anode_n   <= blank_lat ? ANODE_OFF : ~(4'b0001 << idx);
      cathode_n <= seg;
      dp_n      <= ~dp_lat;
    end
  end

endmodule
